muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/mips_pkg.sv | 14 +
 rtl/muldiv_step.sv | 21 ++
 rtl/muldiv_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared multiply/divide op encoding and sequencer state constants.
package mips_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;
  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t S_IDLE = 2'd0;
  localparam muldiv_state_t S_RUN  = 2'd1;
  localparam muldiv_state_t S_FIX  = 2'd2;
  localparam muldiv_state_t S_DONE = 2'd3;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] b,
  input  logic             is_div,
  output logic [2*WIDTH:0] nxt
);
  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shl;
  logic [WIDTH+1:0] diff;
  always_comb begin
    sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, b} : '0);
    shl  = {acc[2*WIDTH-1:0], 1'b0};
    diff = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b0, b};
    // a borrow out of diff means the trial subtraction is undone (restoring)
    nxt  = is_div ? (diff[WIDTH+1] ? shl : {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1})
                  : {1'b0, sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit writing HI/LO.
// Divide path is built only when MULDIV_DIV_EN is defined.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef MULDIV_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif
  muldiv_state_t    state;
  logic [CW-1:0]    cnt;
  logic             div_q, neg_q, neg_r, dz;
  logic [WIDTH-1:0] a_raw, opnd;
  logic [2*WIDTH:0] acc, step_nxt, fix;
  logic             div_in, sgn, sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    div_in = muldiv_op_t'(op) inside {OP_DIV, OP_DIVU};
    sgn    = muldiv_op_t'(op) inside {OP_MULT, OP_DIV};
    sa     = sgn & src_a[WIDTH-1];
    sb     = sgn & src_b[WIDTH-1];
    a_mag  = sa ? -src_a : src_a;
    b_mag  = sb ? -src_b : src_b;
    prod   = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix    = div_q ? {1'b0, rem, quo} : {1'b0, prod};
  end
  assign busy = state != S_IDLE;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc   (acc),
    .b     (opnd),
    .is_div(div_q),
    .nxt   (step_nxt)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && flush) state <= S_IDLE;
      else case (state)
        S_IDLE: if (start && !flush) begin
          div_zero <= 1'b0;
          // without a divide path a divide completes immediately, leaving HI/LO alone
          if (div_in && !DIV_EN) done <= 1'b1;
          else begin
            state <= S_RUN;
            div_q <= div_in;
            cnt   <= '0;
            a_raw <= src_a;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz    <= div_in && src_b == '0;
            opnd  <= div_in ? b_mag : a_mag;
            acc   <= {{(WIDTH+1){1'b0}}, div_in ? a_mag : b_mag};
          end
        end
        S_RUN: if (dz) begin
          acc   <= {1'b0, a_raw, {WIDTH{1'b1}}};
          state <= S_DONE;
        end else begin
          acc <= step_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          acc   <= fix;
          state <= S_DONE;
        end
        default: begin
          hi       <= acc[2*WIDTH-1:WIDTH];
          lo       <= acc[WIDTH-1:0];
          div_zero <= dz;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule
